instruction_fetch: RTL and testbench



---
 rtl/instruction_fetch.sv | 159 +++++++++++++++
 tb/tb_instruction_fetch.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - in-order instruction fetch with response FIFO and redirect flush
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault,
  input  logic        inst_ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;

  logic [31:0]   inst_mem_q  [DEPTH];
  logic [31:0]   pc_mem_q    [DEPTH];
  logic          fault_mem_q [DEPTH];

  logic          grant;
  logic          resp;
  logic          drop;
  logic          push;
  logic          pop;
  logic          misaligned;
  logic [CW:0]   credit_used;
  logic [31:0]   resp_pc;

  // Slots are taken both by buffered words and by requests still in flight,
  // so the FIFO can never overflow whatever the memory latency.
  assign credit_used = {1'b0, count_q} + {1'b0, inflight_q};
  assign mem_req     = ~rst && (state_q == ST_RUN) && (credit_used < DEPTH_W);
  assign mem_addr    = fetch_pc_q;
  assign grant       = mem_req & mem_gnt;

  // A response is only meaningful while something is outstanding.
  assign resp        = mem_rvalid & (inflight_q != '0);
  assign drop        = resp & (discard_q != '0);
  assign push        = resp & (discard_q == '0) & ~redirect;

  assign inst_valid  = (count_q != '0);
  assign pop         = inst_valid & inst_ready & ~redirect;
  assign misaligned  = (redirect_pc[1:0] != 2'b00);

  // Once all stale responses are gone the outstanding requests are one
  // contiguous run ending just below fetch_pc, so the oldest one is derivable.
  assign resp_pc     = fetch_pc_q - (32'(inflight_q) << 2);

  // Head of the FIFO is shown only while valid so idle outputs read as zero.
  assign inst        = inst_valid ? inst_mem_q[rd_ptr_q]  : 32'h0;
  assign inst_pc     = inst_valid ? pc_mem_q[rd_ptr_q]    : 32'h0;
  assign inst_fault  = inst_valid ? fault_mem_q[rd_ptr_q] : 1'b0;

  // Next-state: counters, fetch PC and FIFO pointers; redirect overrides all.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    inflight_d = inflight_q;
    discard_d  = discard_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;

    if (grant) begin
      inflight_d = inflight_d + CW'(1);
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
    if (resp) begin
      inflight_d = inflight_d - CW'(1);
    end
    if (drop) begin
      discard_d = discard_q - CW'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      count_d  = count_d + CW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      count_d  = count_d - CW'(1);
    end

    if (redirect) begin
      // Everything still outstanding after this cycle belongs to the old path.
      discard_d  = inflight_d;
      fetch_pc_d = redirect_pc;
      rd_ptr_d   = '0;
      if (misaligned) begin
        state_d  = ST_FAULT;
        wr_ptr_d = AW'(1);
        count_d  = CW'(1);
      end else begin
        state_d  = ST_RUN;
        wr_ptr_d = '0;
        count_d  = '0;
      end
    end
  end

  // Control state, counters and pointers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // FIFO storage; a misaligned redirect plants the fault entry in slot 0.
  always_ff @(posedge clk) begin
    if (redirect) begin
      if (misaligned) begin
        inst_mem_q[0]  <= 32'h0;
        pc_mem_q[0]    <= redirect_pc;
        fault_mem_q[0] <= 1'b1;
      end
    end else if (push) begin
      inst_mem_q[wr_ptr_q]  <= mem_rdata;
      pc_mem_q[wr_ptr_q]    <= resp_pc;
      fault_mem_q[wr_ptr_q] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed self-checking bench for instruction_fetch
module tb_instruction_fetch;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        mem_gnt, mem_rvalid, redirect, inst_ready;
  logic [31:0] mem_rdata, redirect_pc;
  logic        mem_req, inst_valid, inst_fault;
  logic [31:0] mem_addr, inst, inst_pc;
  logic        w_mem_req, w_inst_valid, w_inst_fault;
  logic [31:0] w_mem_addr, w_inst, w_inst_pc;

  instruction_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_fault(inst_fault), .inst_ready(inst_ready)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_w (
    .clk(clk), .rst(rst),
    .mem_req(w_mem_req), .mem_addr(w_mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .redirect(1'b0), .redirect_pc(32'h0),
    .inst_valid(w_inst_valid), .inst(w_inst), .inst_pc(w_inst_pc),
    .inst_fault(w_inst_fault), .inst_ready(inst_ready)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory responder: in-order, fixed latency 'lat' edges after the grant edge.
  logic [31:0] pend_addr[$];
  int          pend_edge[$];
  int          edge_cnt = 0;
  int          lat = 1;

  initial forever begin
    @(posedge clk);
    edge_cnt++;
  end

  initial begin
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    forever begin
      @(negedge clk); #1;
      mem_rvalid = 1'b0; mem_rdata = 32'h0;
      if (rst) begin
        pend_addr.delete(); pend_edge.delete();
        mem_gnt = 1'b0;
      end else begin
        if (pend_addr.size() > 0 && edge_cnt + 1 >= pend_edge[0] + lat) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem_word(pend_addr[0]);
          void'(pend_addr.pop_front());
          void'(pend_edge.pop_front());
        end
        mem_gnt = 1'b1;
        if (mem_req && mem_gnt) begin
          pend_addr.push_back(mem_addr);
          pend_edge.push_back(edge_cnt + 1);
        end
      end
    end
  end

  // Expected-stream model
  logic [31:0] exp_addr, exp_pc;
  logic        exp_fault;
  int          grants, pops;

  task automatic reset_model();
    exp_addr = 32'h0; exp_pc = 32'h0; exp_fault = 1'b0;
  endtask

  task automatic step();
    @(negedge clk); #2;
  endtask

  task automatic release_reset();
    @(negedge clk); rst = 1'b0; #2;
    reset_model();
  endtask

  task automatic observe();
    if (mem_req && mem_gnt) begin
      check_eq("grant_addr", mem_addr, exp_addr);
      exp_addr += 32'd4;
      grants++;
    end
    if (inst_valid && inst_ready) begin
      check_eq("pop_pc", inst_pc, exp_pc);
      check_eq("pop_inst", inst, exp_fault ? 32'h0 : mem_word(exp_pc));
      check_eq("pop_fault", 32'(inst_fault), 32'(exp_fault));
      exp_pc += 32'd4;
      pops++;
    end
    if (redirect) begin
      exp_pc    = redirect_pc;
      exp_addr  = redirect_pc;
      exp_fault = (redirect_pc[1:0] != 2'b00);
    end
  endtask

  task automatic tick();
    observe();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] wrap_tab [3];
    int first_valid, k, vc;
    wrap_tab[0] = 32'hFFFF_FFF8; wrap_tab[1] = 32'hFFFF_FFFC; wrap_tab[2] = 32'h0000_0000;
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b1;
    grants = 0; pops = 0;
    reset_model();
    repeat (3) step();

    check_eq("rst_mem_req", 32'(mem_req), 0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_inst_valid", 32'(inst_valid), 0);
    check_eq("rst_inst", inst, 32'h0);
    check_eq("rst_inst_pc", inst_pc, 32'h0);
    check_eq("rst_inst_fault", 32'(inst_fault), 0);
    check_eq("rst_wrap_addr", w_mem_addr, 32'hFFFF_FFF8);

    // Streaming with single-cycle memory
    release_reset();
    check_eq("first_req", 32'(mem_req), 1);
    check_eq("first_addr", mem_addr, 32'h0);
    first_valid = -1; k = 0;
    for (int c = 0; c < 16; c++) begin
      if (inst_valid && first_valid < 0) first_valid = c;
      if (mem_req && mem_gnt && k < 3) begin
        check_eq("wrap_req", 32'(w_mem_req), 1);
        check_eq("wrap_addr", w_mem_addr, wrap_tab[k]);
        k++;
      end
      tick();
    end
    check_eq("first_valid_cycle", 32'(first_valid), 2);
    check_eq("run_pops_ge6", 32'(pops >= 6), 1);

    // Decoder stall
    inst_ready = 1'b0; grants = 0;
    repeat (10) tick();
    check_eq("stall_grants_le_depth", 32'(grants <= 2), 1);
    check_eq("stall_req_low", 32'(mem_req), 0);
    check_eq("stall_head_valid", 32'(inst_valid), 1);
    inst_ready = 1'b1; pops = 0;
    repeat (12) tick();
    check_eq("stall_drain_pops", 32'(pops >= 4), 1);

    // Redirect with a same-cycle grant and two stale requests
    lat = 3; rst = 1'b1; repeat (2) step();
    release_reset();
    tick();
    redirect = 1'b1; redirect_pc = 32'h100;
    check_eq("redir_same_cycle_grant", 32'(mem_req && mem_gnt), 1);
    tick();
    redirect = 1'b0;
    check_eq("redir_inst_valid", 32'(inst_valid), 0);
    check_eq("redir_mem_addr", mem_addr, 32'h100);
    check_eq("redir_mem_req", 32'(mem_req), 0);
    pops = 0;
    for (int c = 0; c < 20 && pops == 0; c++) tick();
    check_eq("redir_first_pop", 32'(pops), 1);

    // Misaligned redirect and recovery
    lat = 1;
    repeat (4) tick();
    redirect = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect = 1'b0;
    check_eq("fault_valid", 32'(inst_valid), 1);
    check_eq("fault_flag", 32'(inst_fault), 1);
    check_eq("fault_pc", inst_pc, 32'h102);
    check_eq("fault_inst", inst, 32'h0);
    check_eq("fault_req", 32'(mem_req), 0);
    tick();
    grants = 0; vc = 0;
    repeat (8) begin
      if (inst_valid) vc++;
      tick();
    end
    check_eq("fault_no_grants", 32'(grants), 0);
    check_eq("fault_no_valid", 32'(vc), 0);
    redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    check_eq("resume_addr", mem_addr, 32'h200);
    check_eq("resume_req", 32'(mem_req), 1);
    pops = 0;
    for (int c = 0; c < 20 && pops < 3; c++) tick();
    check_eq("resume_pops", 32'(pops), 3);

    // Asynchronous reset with two requests in flight
    lat = 3; rst = 1'b1; repeat (2) step();
    release_reset();
    tick(); tick();
    check_eq("pre_rst_addr", mem_addr, 32'h8);
    rst = 1'b1; #1;
    check_eq("arst_mem_req", 32'(mem_req), 0);
    check_eq("arst_mem_addr", mem_addr, 32'h0);
    check_eq("arst_inst_valid", 32'(inst_valid), 0);
    check_eq("arst_inst_pc", inst_pc, 32'h0);
    repeat (3) step();
    lat = 1;
    release_reset();
    check_eq("restart_req", 32'(mem_req), 1);
    check_eq("restart_addr", mem_addr, 32'h0);
    pops = 0;
    for (int c = 0; c < 20 && pops < 3; c++) tick();
    check_eq("restart_pops", 32'(pops), 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
